// File: rtl/keypad_entry.sv
// keypad_entry: numeric entry stage between the keypad scanner and the application.
// Buffers up to DIGITS BCD digits for display and handles backspace, clear and enter.
// On enter it converts the buffer to binary, oldest digit first, one digit per cycle,
// and then presents the result on a valid/ready output.
//
// Ports:
//   clk, rst            - clock; synchronous active-high reset
//   key_index/valid     - key stream from the scanner
//   key_ready           - high when a key can be accepted (ENTRY state, not in reset)
//   digits              - BCD display buffer; nibble 0 is the newest digit, unused = F
//   digit_count         - number of buffered digits
//   entry_err           - one-cycle pulse when a key is rejected
//   value/value_valid   - converted result and its valid flag
//   value_ready         - consumer accepts value
module keypad_entry #(
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned VALUE_W = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            key_index,
  input  logic                  key_valid,
  output logic                  key_ready,
  output logic [4*DIGITS-1:0]   digits,
  output logic [3:0]            digit_count,
  output logic                  entry_err,
  output logic [VALUE_W-1:0]    value,
  output logic                  value_valid,
  input  logic                  value_ready
);

  localparam int unsigned BUF_W = 4 * DIGITS;
  localparam logic [BUF_W-1:0] BLANK = '1;

  typedef enum logic [1:0] {
    S_ENTRY,
    S_CONVERT,
    S_OUTPUT
  } state_t;

  state_t               r_state, w_state;
  logic [BUF_W-1:0]     r_digits, w_digits;
  logic [3:0]           r_count, w_count;
  logic [3:0]           r_idx, w_idx;
  logic [VALUE_W-1:0]   r_acc, w_acc;
  logic                 r_err, w_err;
  logic                 r_valid, w_valid;

  logic                 w_key_fire;
  logic [3:0]           w_digit;
  logic [VALUE_W-1:0]   w_acc_x10;

  // Ready is decoded from the state register only, masked while in reset.
  assign key_ready  = (r_state == S_ENTRY) && !rst;
  assign w_key_fire = key_valid && key_ready;

  // Digit currently being folded into the accumulator.
  assign w_digit   = 4'(r_digits >> {r_idx, 2'b00});
  assign w_acc_x10 = (r_acc << 3) + (r_acc << 1) + VALUE_W'(w_digit);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_ENTRY;
      r_digits <= BLANK;
      r_count  <= 4'd0;
      r_idx    <= 4'd0;
      r_acc    <= '0;
      r_err    <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_digits <= w_digits;
      r_count  <= w_count;
      r_idx    <= w_idx;
      r_acc    <= w_acc;
      r_err    <= w_err;
      r_valid  <= w_valid;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    w_state  = r_state;
    w_digits = r_digits;
    w_count  = r_count;
    w_idx    = r_idx;
    w_acc    = r_acc;
    w_err    = 1'b0;
    w_valid  = r_valid;

    case (r_state)
      S_ENTRY: begin
        if (w_key_fire) begin
          if (key_index <= 4'd9) begin
            if (r_count < 4'(DIGITS)) begin
              w_digits = (r_digits << 4) | BUF_W'(key_index);
              w_count  = r_count + 4'd1;
            end else begin
              w_err = 1'b1;
            end
          end else if (key_index == 4'd10) begin
            if (r_count != 4'd0) begin
              // Shift out the newest digit; the vacated top nibble becomes blank.
              w_digits = (r_digits >> 4) | (BLANK << (BUF_W - 4));
              w_count  = r_count - 4'd1;
            end else begin
              w_err = 1'b1;
            end
          end else if (key_index == 4'd11) begin
            w_digits = BLANK;
            w_count  = 4'd0;
          end else if (key_index == 4'd12) begin
            // Empty enter is ignored; otherwise start from the oldest digit.
            if (r_count != 4'd0) begin
              w_acc   = '0;
              w_idx   = r_count - 4'd1;
              w_state = S_CONVERT;
            end
          end
        end
      end

      S_CONVERT: begin
        w_acc = w_acc_x10;
        w_idx = r_idx - 4'd1;
        if (r_idx == 4'd0) begin
          w_state = S_OUTPUT;
          w_valid = 1'b1;
        end
      end

      S_OUTPUT: begin
        if (value_ready) begin
          w_digits = BLANK;
          w_count  = 4'd0;
          w_valid  = 1'b0;
          w_state  = S_ENTRY;
        end
      end

      default: w_state = S_ENTRY;
    endcase
  end

  assign digits      = r_digits;
  assign digit_count = r_count;
  assign entry_err   = r_err;
  assign value       = r_acc;
  assign value_valid = r_valid;

endmodule

// File: tb/tb_keypad_entry.sv
// Testbench for keypad_entry: directed scenarios plus random key/ready/reset traffic,
// checked every cycle against a digit-list reference model.
module tb_keypad_entry;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key_index = 4'd0;
  logic        key_valid = 1'b0;
  logic        key_ready;
  logic [15:0] digits;
  logic [3:0]  digit_count;
  logic        entry_err;
  logic [13:0] value;
  logic        value_valid;
  logic        value_ready = 1'b0;

  always #5 clk = ~clk;

  keypad_entry #(.DIGITS(4), .VALUE_W(14)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_index   (key_index),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .digits      (digits),
    .digit_count (digit_count),
    .entry_err   (entry_err),
    .value       (value),
    .value_valid (value_valid),
    .value_ready (value_ready)
  );

  // Reference model: list of entered digits (oldest first) and a coarse phase.
  int q[$];
  int mode;       // 0 entry, 1 converting, 2 result offered
  int left;       // conversion cycles remaining
  int exp_val;
  bit val_known;
  bit exp_err;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_digits();
    logic [15:0] e;
    int n;
    e = 16'hFFFF;
    n = q.size();
    for (int i = 0; i < n; i++) e[4*i +: 4] = 4'(q[n-1-i]);
    return e;
  endfunction

  function automatic int exp_value();
    int v;
    int n;
    v = 0;
    n = q.size();
    for (int i = 0; i < n; i++) v += q[i] * (10 ** (n - 1 - i));
    return v;
  endfunction

  task automatic mdl_reset();
    q.delete();
    mode      = 0;
    left      = 0;
    exp_val   = 0;
    val_known = 1'b1;
    exp_err   = 1'b0;
  endtask

  task automatic mdl_step(input bit kv, input int ki, input bit vr, input bit r);
    exp_err = 1'b0;
    if (r) begin
      mdl_reset();
      return;
    end
    case (mode)
      0: if (kv) begin
        if (ki <= 9) begin
          if (q.size() < 4) q.push_back(ki);
          else exp_err = 1'b1;
        end else if (ki == 10) begin
          if (q.size() > 0) void'(q.pop_back());
          else exp_err = 1'b1;
        end else if (ki == 11) begin
          q.delete();
        end else if (ki == 12 && q.size() > 0) begin
          mode      = 1;
          left      = q.size();
          exp_val   = exp_value();
          val_known = 1'b0;
        end
      end
      1: begin
        left--;
        if (left == 0) begin
          mode      = 2;
          val_known = 1'b1;
        end
      end
      default: if (vr) begin
        q.delete();
        mode = 0;
      end
    endcase
  endtask

  task automatic check_outputs();
    check_eq("key_ready", 32'(key_ready), 32'((mode == 0) && !rst));
    check_eq("digits", 32'(digits), 32'(exp_digits()));
    check_eq("digit_count", 32'(digit_count), 32'(q.size()));
    check_eq("entry_err", 32'(entry_err), 32'(exp_err));
    check_eq("value_valid", 32'(value_valid), 32'(mode == 2));
    if (val_known) check_eq("value", 32'(value), 32'(exp_val));
  endtask

  // One clock: drive inputs, step the model at the edge, check at the falling edge.
  task automatic cyc(input bit kv, input int ki, input bit vr, input bit r);
    key_valid   = kv;
    key_index   = 4'(ki);
    value_ready = vr;
    rst         = r;
    @(posedge clk);
    mdl_step(kv, ki, vr, r);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic key(input int k);
    cyc(1'b1, k, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n, input bit vr);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, vr, 1'b0);
  endtask

  initial begin
    mdl_reset();
    cyc(1'b0, 0, 1'b0, 1'b1);
    cyc(1'b0, 0, 1'b0, 1'b1);
    check_eq("reset_digits", 32'(digits), 32'h0000FFFF);

    // 1234, conversion latency, stall, handshake.
    key(1); key(2); key(3); key(4);
    check_eq("buf_1234", 32'(digits), 32'h00001234);
    key(12);
    idle(3, 1'b0);
    check_eq("not_yet_valid", 32'(value_valid), 32'd0);
    idle(1, 1'b0);
    check_eq("valid_after_4", 32'(value_valid), 32'd1);
    check_eq("value_1234", 32'(value), 32'd1234);
    idle(5, 1'b0);
    idle(1, 1'b1);
    check_eq("cleared_after_hs", 32'(digits), 32'h0000FFFF);

    // Overflow digit rejected, then 9999.
    key(9); key(9); key(9); key(9); key(5);
    check_eq("overflow_err", 32'(entry_err), 32'd1);
    idle(1, 1'b0);
    key(12);
    idle(4, 1'b0);
    check_eq("value_9999", 32'(value), 32'd9999);
    idle(1, 1'b1);

    // Backspace handling.
    key(7); key(3); key(10); key(5);
    check_eq("buf_ff75", 32'(digits), 32'h0000FF75);
    key(10); key(10); key(10);
    check_eq("bs_empty_err", 32'(entry_err), 32'd1);

    // Clear then empty enter, then leading zeros.
    key(4); key(2); key(11); key(12);
    idle(3, 1'b0);
    key(0); key(0); key(8); key(12);
    idle(3, 1'b0);
    check_eq("value_8", 32'(value), 32'd8);
    idle(1, 1'b1);

    // Key held during conversion/output is consumed only after the handshake.
    key(5); key(12);
    cyc(1'b1, 6, 1'b0, 1'b0);
    cyc(1'b1, 6, 1'b0, 1'b0);
    cyc(1'b1, 6, 1'b1, 1'b0);
    cyc(1'b1, 6, 1'b0, 1'b0);
    check_eq("held_key_taken", 32'(digits), 32'h0000FFF6);
    key(11);

    // Reset during the second conversion cycle discards the entry.
    key(1); key(2); key(3); key(12);
    idle(1, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b1);
    idle(6, 1'b1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 4) != 0, $urandom_range(0, 15), ($urandom % 3) == 0,
          ($urandom % 200) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
